// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with zero-latency reads and one write
// port. A per-register scoreboard (pending) bit is set on issue and cleared
// when the register is written. A small FSM bulk-clears registers and
// scoreboard bits, one index per cycle.
// Optional feature: define RF_BYPASS_EN to forward an accepted write to
// both read ports within the same cycle.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            SB_SET,
  input  logic [AW-1:0]   SB_A,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            CLR_REQ,
  output logic            CLR_BUSY,
  output logic            CLR_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     idx_nx;

  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   pending;

  logic              wr_ok;
  logic              set_ok;
  logic              clr_step;

  // Writes and scoreboard marks are locked out while the clear sequence runs
  // so a partially cleared array never gets stale data re-injected.
  assign CLR_BUSY = (state != IDLE);
  assign CLR_DONE = (state == DONE);
  assign clr_step = (state == CLEAR);
  assign wr_ok    = WE && (A3 != '0) && !CLR_BUSY;
  assign set_ok   = SB_SET && (SB_A != '0) && !CLR_BUSY;

  // Clear FSM state and index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= IDX_FIRST;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Clear FSM next state: walk idx from 1 to NREG-1, then one DONE cycle.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        idx_nx = IDX_FIRST;
        if (CLR_REQ) begin
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        idx_nx = idx + AW'(1);
        if (idx == IDX_LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = IDX_FIRST;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = IDX_FIRST;
      end
    endcase
  end

  // Register array: bulk-clear step has priority, entry 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_step) begin
      regs[idx] <= '0;
    end else if (wr_ok) begin
      regs[A3] <= WD3;
    end
  end

  // Scoreboard: clear step first, then a new mark beats a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (clr_step && (idx == AW'(i))) begin
          pending[i] <= 1'b0;
        end else if (set_ok && (SB_A == AW'(i))) begin
          pending[i] <= 1'b1;
        end else if (wr_ok && (A3 == AW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = wr_ok && (A3 == A1);
  assign fwd2 = wr_ok && (A3 == A2);

  // Read ports with same-cycle forwarding of the accepted write.
  always_comb begin
    RD1   = (A1 == '0) ? '0 : regs[A1];
    RD2   = (A2 == '0) ? '0 : regs[A2];
    BUSY1 = pending[A1];
    BUSY2 = pending[A2];
    if (fwd1) begin
      RD1   = WD3;
      BUSY1 = 1'b0;
    end
    if (fwd2) begin
      RD2   = WD3;
      BUSY2 = 1'b0;
    end
  end
`else
  // Read ports: current array contents; a write becomes visible after the edge.
  always_comb begin
    RD1   = (A1 == '0) ? '0 : regs[A1];
    RD2   = (A2 == '0) ? '0 : regs[A2];
    BUSY1 = pending[A1];
    BUSY2 = pending[A2];
  end
`endif

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits (>=8).
REQ-002 SHALL provide parameter NREG, default 32, register count (power of 2, 4..64); localparam AW = log2(NREG).
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports A1, A2  in  AW  read addresses; RD1, RD2  out  XLEN  read data.
REQ-006 SHALL have ports WE  in  1, A3  in  AW, WD3  in  XLEN  write enable, address, data.
REQ-007 SHALL have ports SB_SET  in  1, SB_A  in  AW  scoreboard mark request and index.
REQ-008 SHALL have ports BUSY1, BUSY2  out  1  pending-write status of A1, A2.
REQ-009 SHALL have ports CLR_REQ  in  1 start bulk clear; CLR_BUSY  out  1 clear in progress; CLR_DONE  out  1 one-cycle completion pulse.

Function
REQ-010 SHALL hold NREG registers of XLEN bits; register 0 reads 0 always; writes to index 0 are discarded.
REQ-011 SHALL drive RD1/RD2 combinationally from An (zero-latency read).
REQ-012 SHALL write WD3 to reg[A3] at the rising edge when WE=1, A3!=0 and CLR_BUSY=0.
REQ-013 SHALL hold one pending bit per register; bit 0 permanently 0.
REQ-014 SHALL set pending[SB_A] at the edge when SB_SET=1, SB_A!=0, CLR_BUSY=0.
REQ-015 SHALL clear pending[A3] at the edge of an accepted write (REQ-012).
REQ-016 SHALL, on SB_SET and accepted write to the same index in one cycle, leave the bit set (set wins).
REQ-017 SHALL drive BUSYn = pending[An] (subject to REQ-025).
REQ-018 SHALL implement clear FSM with states IDLE, CLEAR, DONE; IDX counter of AW bits.
REQ-019 SHALL in IDLE on CLR_REQ=1 go to CLEAR with IDX=1; otherwise stay in IDLE.
REQ-020 SHALL in CLEAR, each cycle, zero reg[IDX] and pending[IDX], increment IDX; after IDX=NREG-1 go to DONE (NREG-1 cycles in CLEAR).
REQ-021 SHALL in DONE assert CLR_DONE for exactly that cycle, then return to IDLE.
REQ-022 SHALL assert CLR_BUSY in CLEAR and DONE; ignore WE, SB_SET and CLR_REQ while CLR_BUSY=1 (no queuing).
REQ-023 SHALL return current array contents on reads during CLEAR (partially cleared state is visible).

Reset
REQ-024 SHALL, on rst_n=0 asynchronously: all registers 0, all pending bits 0, FSM IDLE, IDX 1; RD1/RD2=0, BUSY1/BUSY2=0, CLR_BUSY=0, CLR_DONE=0; reset asserted during CLEAR aborts it with no CLR_DONE.

Configuration
REQ-025 SHALL honour macro RF_BYPASS_EN: when defined, if WE=1, CLR_BUSY=0, A3!=0 and A3==An, RDn SHALL equal WD3 and BUSYn SHALL be 0 in the same cycle; when undefined, RDn shows the pre-write value until the edge and BUSYn = pending[An].

Verification
REQ-026 SHALL cover: reset, write reg5=0xDEADBEEF, A1=5 -> RD1=0xDEADBEEF next cycle; write reg0=0x1234, A2=0 -> RD2=0.
REQ-027 SHALL cover: SB_SET SB_A=7 -> BUSY1=1 (A1=7) next cycle; WE A3=7 WD3=0x55 -> BUSY1=0 after edge; same-cycle SB_SET 7 + WE 7 -> BUSY1 stays 1.
REQ-028 SHALL cover: fill regs 1..31 with index value, pulse CLR_REQ -> CLR_BUSY high 32 cycles, CLR_DONE single pulse on cycle 32, all reads 0 afterwards.
REQ-029 SHALL cover: WE A3=3 WD3=0xAA and SB_SET 4 during CLEAR -> reg3=0, pending[4]=0 after DONE.
REQ-030 SHALL cover: with RF_BYPASS_EN, WE A3=9 WD3=0x77, A1=9 same cycle -> RD1=0x77, BUSY1=0; without macro -> RD1=old value.
REQ-031 SHALL cover: rst_n low mid-CLEAR (IDX=10) -> immediate IDLE, CLR_BUSY=0, no CLR_DONE, all regs 0.
